rr_stream_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready output stream between N valid/ready requester streams. Sits upstream of a shared consumer (or a handshake buffer feeding it) and multiplexes producers onto it. Output is a single registered stage, so there is no combinational path from `m_ready` to `m_data`. Packet-aware: once a multi-beat packet starts, the grant is locked to that requester until its last beat is accepted.

---
 rtl/rr_arb_pkg.sv | 15 +
 rtl/rr_stream_arbiter_if.sv | 32 +++
 rtl/rr_pick.sv | 35 +++
 rtl/rr_stream_arbiter.sv | 130 +++++++++++++
 tb/tb_rr_stream_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Holds the lock FSM state type and the requester-index width function.
package rr_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_stream_arbiter_if.sv
// Handshake bundle for the arbiter: N requester streams in, one stream out.
// master = requesters plus downstream consumer, slave = the arbiter itself.
interface rr_stream_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8
);

    localparam int unsigned IDX_W = idx_w(N);

    logic [N-1:0]       s_valid;
    logic [N*WIDTH-1:0] s_data;
    logic [N-1:0]       s_last;
    logic [N-1:0]       s_ready;
    logic               m_valid;
    logic [WIDTH-1:0]   m_data;
    logic               m_last;
    logic [IDX_W-1:0]   m_sel;
    logic               m_ready;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_sel
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, m_sel
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr,
// wrapping modulo N (ptr is always below N).
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    localparam logic [IDX_W:0] NumReq = (IDX_W+1)'(N);

    logic [IDX_W:0] cand;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!gnt_any && req[cand[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Packet-aware round-robin arbiter multiplexing N valid/ready streams onto one
// registered output stage; a started multi-beat packet keeps the grant.
module rr_stream_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    rr_stream_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = idx_w(N);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic             m_valid_q;
    logic [WIDTH-1:0] m_data_q;
    logic             m_last_q;
    logic [IDX_W-1:0] m_sel_q;

    logic             go;
    logic             load;
    logic [N-1:0]     req;
    logic [IDX_W-1:0] pick_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [WIDTH-1:0] gnt_data;
    logic             gnt_last;
    logic [N-1:0]     s_ready;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == LastIdx) ? '0 : i + 1'b1;
    endfunction

    // While locked only the owning requester is visible, so the picker
    // can only return lock_idx.
    always_comb begin
        go       = !m_valid_q || bus.m_ready;
        req      = '0;
        pick_ptr = ptr_q;
        if (state_q == LOCKED) begin
            req[lock_idx_q] = bus.s_valid[lock_idx_q];
            pick_ptr        = lock_idx_q;
        end else begin
            req = bus.s_valid;
        end
    end

    rr_pick #(
        .N (N)
    ) u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign load = rst_n && go && gnt_any;

    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                gnt_data = bus.s_data[i*WIDTH +: WIDTH];
                gnt_last = bus.s_last[i];
            end
        end
    end

    always_comb begin
        s_ready = '0;
        if (load) begin
            s_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            m_sel_q    <= '0;
        end else begin
            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= gnt_data;
                m_last_q  <= gnt_last;
                m_sel_q   <= gnt_idx;
            end else if (bus.m_ready) begin
                m_valid_q <= 1'b0;
            end

            // Pointer moves only when a last beat is accepted.
            if (load) begin
                unique case (state_q)
                    IDLE: begin
                        if (gnt_last) begin
                            ptr_q <= wrap_inc(gnt_idx);
                        end else begin
                            lock_idx_q <= gnt_idx;
                            state_q    <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (gnt_last) begin
                            ptr_q   <= wrap_inc(lock_idx_q);
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_sel   = m_sel_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a queue-free behavioural reference model.
module tb_rr_stream_arbiter;
    import rr_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_stream_arbiter_if #(.N(N), .WIDTH(W)) bus ();
    rr_stream_arbiter_if #(.N(3), .WIDTH(W)) bus3 ();

    rr_stream_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rr_stream_arbiter #(.N(3), .WIDTH(W)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: what the output stage holds and the fairness state.
    bit           mv;
    bit           ml;
    logic [W-1:0] md;
    int           ms;
    int           mptr;
    int           mlock;  // -1 when no packet is in progress
    logic [N-1:0] acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant();
        if (!rst_n) return -1;
        if (mv && !bus.m_ready) return -1;
        if (mlock >= 0) return bus.s_valid[mlock] ? mlock : -1;
        for (int k = 0; k < N; k++) begin
            if (bus.s_valid[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    // Compare everything at the falling edge, then advance the model across
    // the rising edge; returns 1 time unit after that edge.
    task automatic cycle(input string tag);
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        g       = model_grant();
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        check({tag, ".rdy"},  32'(bus.s_ready), 32'(exp_rdy));
        check({tag, ".vld"},  32'(bus.m_valid), 32'(mv));
        check({tag, ".data"}, 32'(bus.m_data),  32'(md));
        check({tag, ".last"}, 32'(bus.m_last),  32'(ml));
        check({tag, ".sel"},  32'(bus.m_sel),   32'(ms));
        acc = bus.s_ready & bus.s_valid;
        if (!rst_n) begin
            mv = 0; ml = 0; md = '0; ms = 0; mptr = 0; mlock = -1;
        end else if (g >= 0) begin
            mv = 1;
            md = bus.s_data[g*W +: W];
            ml = bus.s_last[g];
            ms = g;
            if (ml) begin
                mptr  = (g + 1) % N;
                mlock = -1;
            end else begin
                mlock = g;
            end
        end else if (bus.m_ready) begin
            mv = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] d, input bit last);
        bus.s_valid[i]         = 1'b1;
        bus.s_data[i*W +: W]   = d;
        bus.s_last[i]          = last;
    endtask

    task automatic clr_req(input int i);
        bus.s_valid[i] = 1'b0;
    endtask

    initial begin
        bus.s_valid  = '0;
        bus.s_data   = '0;
        bus.s_last   = '0;
        bus.m_ready  = 1'b0;
        bus3.s_valid = '0;
        bus3.s_data  = '0;
        bus3.s_last  = '0;
        bus3.m_ready = 1'b1;
        mv = 0; ml = 0; md = '0; ms = 0; mptr = 0; mlock = -1;
        acc = '0;

        // Reset
        cycle("rst0");
        cycle("rst1");
        rst_n = 1'b1;

        // Single requester at full speed
        bus.m_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            set_req(1, W'(k), 1'b1);
            cycle("single");
            check("single.exp_data", 32'(bus.m_data), 32'(k));
            check("single.exp_sel",  32'(bus.m_sel),  32'd1);
        end
        clr_req(1);
        cycle("single_end");

        // Fairness from a fresh reset
        rst_n = 1'b0;
        cycle("fair_rst");
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, W'(8'h10 * i), 1'b1);
        for (int k = 0; k < 8; k++) begin
            cycle("fair");
            check("fair.exp_sel",  32'(bus.m_sel),  32'(k % N));
            check("fair.exp_data", 32'(bus.m_data), 32'(8'h10 * (k % N)));
        end
        for (int i = 0; i < N; i++) clr_req(i);
        cycle("fair_end");

        // Packet lock: move ptr to 2, then requester 2 streams over requester 0
        set_req(1, 8'h77, 1'b1);
        cycle("lock_pre");
        clr_req(1);
        set_req(0, 8'h55, 1'b1);
        for (int k = 0; k < 3; k++) begin
            set_req(2, W'(8'hA0 + k), k == 2);
            #1;
            check("lock.rdy0", 32'(bus.s_ready[0]), 32'd0);
            cycle("lock");
            check("lock.exp_data", 32'(bus.m_data), 32'(8'hA0 + k));
        end
        clr_req(2);
        cycle("lock_after");
        check("lock.exp_55", 32'(bus.m_data), 32'h55);
        check("lock.exp_sel0", 32'(bus.m_sel), 32'd0);
        clr_req(0);
        cycle("lock_end");

        // Back-pressure
        bus.m_ready = 1'b0;
        set_req(3, 8'h33, 1'b1);
        cycle("bp_load");
        clr_req(3);
        set_req(0, 8'h44, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle("bp_stall");
            check("bp.exp_data", 32'(bus.m_data),  32'h33);
            check("bp.exp_vld",  32'(bus.m_valid), 32'd1);
            check("bp.exp_sel",  32'(bus.m_sel),   32'd3);
            check("bp.exp_rdy",  32'(bus.s_ready), 32'd0);
        end
        bus.m_ready = 1'b1;
        cycle("bp_release");
        check("bp.exp_next", 32'(bus.m_data), 32'h44);
        clr_req(0);
        cycle("bp_end");

        // Reset while locked on requester 1
        set_req(1, 8'hB0, 1'b0);
        cycle("rmid_lock");
        set_req(1, 8'hB1, 1'b0);
        set_req(0, 8'hC0, 1'b1);
        rst_n = 1'b0;
        cycle("rmid_rst");
        check("rmid.exp_vld", 32'(bus.m_valid), 32'd0);
        check("rmid.exp_sel", 32'(bus.m_sel),   32'd0);
        rst_n = 1'b1;
        cycle("rmid_first");
        check("rmid.exp_grant0", 32'(bus.m_sel),  32'd0);
        check("rmid.exp_data",   32'(bus.m_data), 32'hC0);
        for (int i = 0; i < N; i++) clr_req(i);
        cycle("rmid_end");

        // Pointer wrap with N=3: ptr reaches 2, then 2 wins before 0
        bus3.s_last              = 3'b111;
        bus3.s_data[1*W +: W]    = 8'h11;
        bus3.s_valid             = 3'b010;
        cycle("wrap_a");
        check("wrap.sel1", 32'(bus3.m_sel), 32'd1);
        bus3.s_data[0*W +: W] = 8'h20;
        bus3.s_data[2*W +: W] = 8'h22;
        bus3.s_valid          = 3'b101;
        #1;
        check("wrap.rdy2", 32'(bus3.s_ready), 32'b100);
        cycle("wrap_b");
        check("wrap.sel2",  32'(bus3.m_sel),  32'd2);
        check("wrap.data2", 32'(bus3.m_data), 32'h22);
        bus3.s_valid = 3'b001;
        #1;
        check("wrap.rdy0", 32'(bus3.s_ready), 32'b001);
        cycle("wrap_c");
        check("wrap.sel0",  32'(bus3.m_sel),  32'd0);
        check("wrap.data0", 32'(bus3.m_data), 32'h20);
        bus3.s_valid = 3'b000;

        // Random traffic with occasional resets
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) clr_req(i);
                if (!bus.s_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, W'($urandom), $urandom_range(0, 2) == 0);
                end
            end
            bus.m_ready = ($urandom_range(0, 3) != 0);
            rst_n       = ($urandom_range(0, 199) != 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
